// File: rtl/updown_mod_counter.sv
// Up/down counter over 0..MODULUS-1 with load, enable, wrap/saturate mode and boundary flags.
// Optional macro COUNTER_PRESCALE_EN adds a prescaler so the counter steps every (prescale+1)-th enabled cycle.
module updown_mod_counter #(
    parameter int WIDTH     = 4,
    parameter int MODULUS   = 2**WIDTH,
    parameter bit SATURATE  = 1'b0,
    parameter bit INIT_DOWN = 1'b1
`ifdef COUNTER_PRESCALE_EN
    ,
    parameter int PRESCALE_WIDTH = 4
`endif
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             en,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
`ifdef COUNTER_PRESCALE_EN
    input  logic [PRESCALE_WIDTH-1:0] prescale,
`endif
    output logic [WIDTH-1:0] count,
    output logic             at_term,
    output logic             tc_pulse
);

    generate
        if (MODULUS < 2 || MODULUS > 2**WIDTH) begin : g_bad_modulus
            $error("updown_mod_counter: MODULUS must lie in 2..2**WIDTH");
        end
    endgenerate

    // One extra bit so MODULUS == 2**WIDTH is representable in compares.
    localparam logic [WIDTH:0] MOD_X = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH:0] ONE_X = (WIDTH+1)'(1);
    localparam logic [WIDTH:0] MAX_X = MOD_X - ONE_X;
    localparam logic [WIDTH:0] CLR_X = INIT_DOWN ? MAX_X : '0;

    logic [WIDTH:0] count_x;
    logic [WIDTH:0] step_x;
    logic [WIDTH:0] load_x;
    logic           step;
    logic           unused_msb;

    assign count_x    = {1'b0, count};
    assign at_term    = up_down ? (count_x == MAX_X) : (count_x == '0);
    assign unused_msb = step_x[WIDTH] ^ load_x[WIDTH];

    always_comb begin
        step_x = count_x;
        if (up_down) begin
            if (count_x == MAX_X) step_x = SATURATE ? count_x : '0;
            else                  step_x = count_x + ONE_X;
        end else begin
            if (count_x == '0)    step_x = SATURATE ? count_x : MAX_X;
            else                  step_x = count_x - ONE_X;
        end
        load_x = ({1'b0, load_value} < MOD_X) ? {1'b0, load_value} : MAX_X;
    end

`ifdef COUNTER_PRESCALE_EN
    logic [PRESCALE_WIDTH-1:0] pre_cnt;

    // >= rather than == so a prescale lowered mid-period cannot strand pre_cnt above it.
    assign step = en && (pre_cnt >= prescale);

    always_ff @(posedge clk) begin
        if (clear || load) begin
            pre_cnt <= '0;
        end else if (en) begin
            if (pre_cnt >= prescale) pre_cnt <= '0;
            else                     pre_cnt <= pre_cnt + 1'b1;
        end
    end
`else
    assign step = en;
`endif

    always_ff @(posedge clk) begin
        if (clear) begin
            count    <= CLR_X[WIDTH-1:0];
            tc_pulse <= 1'b0;
        end else if (load) begin
            count    <= load_x[WIDTH-1:0];
            tc_pulse <= 1'b0;
        end else if (step) begin
            count    <= step_x[WIDTH-1:0];
            tc_pulse <= at_term;
        end else begin
            tc_pulse <= 1'b0;
        end
    end

endmodule

// File: tb/tb_updown_mod_counter.sv
// Directed bench: a wrapping and a saturating MODULUS=10 counter driven with shared stimulus.
module tb_updown_mod_counter;

    logic       clk = 1'b0;
    logic       clear = 1'b0;
    logic       en = 1'b0;
    logic       up_down = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_value = '0;
`ifdef COUNTER_PRESCALE_EN
    logic [3:0] prescale = '0;
`endif
    logic [3:0] count_w, count_s;
    logic       at_term_w, at_term_s;
    logic       tc_w, tc_s;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    updown_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0), .INIT_DOWN(1'b1)) dut_w (
        .clk(clk), .clear(clear), .en(en), .up_down(up_down), .load(load),
        .load_value(load_value),
`ifdef COUNTER_PRESCALE_EN
        .prescale(prescale),
`endif
        .count(count_w), .at_term(at_term_w), .tc_pulse(tc_w)
    );

    updown_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1), .INIT_DOWN(1'b1)) dut_s (
        .clk(clk), .clear(clear), .en(en), .up_down(up_down), .load(load),
        .load_value(load_value),
`ifdef COUNTER_PRESCALE_EN
        .prescale(prescale),
`endif
        .count(count_s), .at_term(at_term_s), .tc_pulse(tc_s)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clear = 1'b1; en = 1'b0; load = 1'b0; up_down = 1'b0;
        tick();
        clear = 1'b0;
        n_cmp++; if (count_w !== 4'd9) begin n_err++; $display("FAIL reset_count_w got %0d want 9", count_w); end
        n_cmp++; if (count_s !== 4'd9) begin n_err++; $display("FAIL reset_count_s got %0d want 9", count_s); end
        n_cmp++; if (tc_w !== 1'b0) begin n_err++; $display("FAIL reset_tc got %b want 0", tc_w); end
        #1;
        n_cmp++; if (at_term_w !== 1'b0) begin n_err++; $display("FAIL reset_at_term_down got %b want 0", at_term_w); end
        up_down = 1'b1;
        #1;
        n_cmp++; if (at_term_w !== 1'b1) begin n_err++; $display("FAIL reset_at_term_up got %b want 1", at_term_w); end
    endtask

    task automatic test_down_wrap();
        logic [3:0] exp_c [10] = '{4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd9};
        clear = 1'b1; tick(); clear = 1'b0;
        en = 1'b1; up_down = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_cmp++; if (count_w !== exp_c[i]) begin n_err++; $display("FAIL down_count[%0d] got %0d want %0d", i, count_w, exp_c[i]); end
            n_cmp++; if (tc_w !== (i == 9)) begin n_err++; $display("FAIL down_tc[%0d] got %b want %b", i, tc_w, (i == 9)); end
        end
        en = 1'b0;
        tick();
        n_cmp++; if (tc_w !== 1'b0) begin n_err++; $display("FAIL down_tc_drop got %b want 0", tc_w); end
        n_cmp++; if (count_w !== 4'd9) begin n_err++; $display("FAIL down_hold got %0d want 9", count_w); end
    endtask

    task automatic test_up_wrap();
        clear = 1'b1; tick(); clear = 1'b0;
        en = 1'b1; up_down = 1'b1;
        tick();
        n_cmp++; if (count_w !== 4'd0) begin n_err++; $display("FAIL up_first got %0d want 0", count_w); end
        n_cmp++; if (tc_w !== 1'b1) begin n_err++; $display("FAIL up_first_tc got %b want 1", tc_w); end
        n_cmp++; if (count_s !== 4'd9) begin n_err++; $display("FAIL up_sat_hold got %0d want 9", count_s); end
        n_cmp++; if (tc_s !== 1'b1) begin n_err++; $display("FAIL up_sat_tc got %b want 1", tc_s); end
        for (int i = 1; i <= 9; i++) begin
            tick();
            n_cmp++; if (count_w !== 4'(i)) begin n_err++; $display("FAIL up_count[%0d] got %0d want %0d", i, count_w, i); end
            n_cmp++; if (tc_w !== 1'b0) begin n_err++; $display("FAIL up_tc[%0d] got %b want 0", i, tc_w); end
        end
        en = 1'b0;
    endtask

    task automatic test_saturate();
        logic [3:0] exp_s [4] = '{4'd9, 4'd9, 4'd9, 4'd9};
        logic       exp_t [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        logic [3:0] exp_w [4] = '{4'd9, 4'd0, 4'd1, 4'd2};
        load = 1'b1; load_value = 4'd8; tick(); load = 1'b0;
        n_cmp++; if (count_s !== 4'd8) begin n_err++; $display("FAIL sat_load got %0d want 8", count_s); end
        en = 1'b1; up_down = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++; if (count_s !== exp_s[i]) begin n_err++; $display("FAIL sat_count[%0d] got %0d want %0d", i, count_s, exp_s[i]); end
            n_cmp++; if (tc_s !== exp_t[i]) begin n_err++; $display("FAIL sat_tc[%0d] got %b want %b", i, tc_s, exp_t[i]); end
            n_cmp++; if (count_w !== exp_w[i]) begin n_err++; $display("FAIL sat_wrap_ref[%0d] got %0d want %0d", i, count_w, exp_w[i]); end
        end
        en = 1'b0;
        // Saturated low boundary: holds at 0 and still pulses.
        load = 1'b1; load_value = 4'd0; tick(); load = 1'b0;
        en = 1'b1; up_down = 1'b0;
        tick();
        n_cmp++; if (count_s !== 4'd0) begin n_err++; $display("FAIL sat_low_hold got %0d want 0", count_s); end
        n_cmp++; if (tc_s !== 1'b1) begin n_err++; $display("FAIL sat_low_tc got %b want 1", tc_s); end
        en = 1'b0;
    endtask

    task automatic test_load_clamp();
        load = 1'b1; load_value = 4'd13; tick();
        n_cmp++; if (count_w !== 4'd9) begin n_err++; $display("FAIL clamp13 got %0d want 9", count_w); end
        load_value = 4'd10; tick();
        n_cmp++; if (count_w !== 4'd9) begin n_err++; $display("FAIL clamp10 got %0d want 9", count_w); end
        load_value = 4'd3; en = 1'b1; up_down = 1'b1; tick();
        n_cmp++; if (count_w !== 4'd3) begin n_err++; $display("FAIL load_over_en got %0d want 3", count_w); end
        clear = 1'b1; tick();
        clear = 1'b0; load = 1'b0; en = 1'b0;
        n_cmp++; if (count_w !== 4'd9) begin n_err++; $display("FAIL clear_wins got %0d want 9", count_w); end
        n_cmp++; if (tc_w !== 1'b0) begin n_err++; $display("FAIL clear_wins_tc got %b want 0", tc_w); end
    endtask

    task automatic test_toggle();
        logic [3:0] exp_c [4] = '{4'd6, 4'd5, 4'd6, 4'd5};
        load = 1'b1; load_value = 4'd5; tick(); load = 1'b0;
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            up_down = (i % 2 == 0);
            tick();
            n_cmp++; if (count_w !== exp_c[i]) begin n_err++; $display("FAIL toggle_count[%0d] got %0d want %0d", i, count_w, exp_c[i]); end
            n_cmp++; if (at_term_w !== 1'b0) begin n_err++; $display("FAIL toggle_at_term[%0d] got %b want 0", i, at_term_w); end
        end
        en = 1'b0; up_down = 1'b0;
        load = 1'b1; load_value = 4'd0; tick(); load = 1'b0;
        n_cmp++; if (at_term_w !== 1'b1) begin n_err++; $display("FAIL zero_at_term got %b want 1", at_term_w); end
        up_down = 1'b1;
        #1;
        n_cmp++; if (at_term_w !== 1'b0) begin n_err++; $display("FAIL zero_flip_at_term got %b want 0", at_term_w); end
    endtask

`ifdef COUNTER_PRESCALE_EN
    task automatic test_prescale();
        logic [3:0] exp_c [6] = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd2};
        logic [3:0] exp_l [3] = '{4'd5, 4'd5, 4'd6};
        prescale = 4'd2;
        load = 1'b1; load_value = 4'd0; tick(); load = 1'b0;
        en = 1'b1; up_down = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_cmp++; if (count_w !== exp_c[i]) begin n_err++; $display("FAIL pre_count[%0d] got %0d want %0d", i, count_w, exp_c[i]); end
        end
        tick();
        load = 1'b1; load_value = 4'd5; tick(); load = 1'b0;
        n_cmp++; if (count_w !== 4'd5) begin n_err++; $display("FAIL pre_load got %0d want 5", count_w); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (count_w !== exp_l[i]) begin n_err++; $display("FAIL pre_restart[%0d] got %0d want %0d", i, count_w, exp_l[i]); end
        end
        en = 1'b0; prescale = 4'd0;
    endtask
`endif

    initial begin
        test_reset();
        test_down_wrap();
        test_up_wrap();
        test_saturate();
        test_load_clamp();
        test_toggle();
`ifdef COUNTER_PRESCALE_EN
        test_prescale();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
